// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
package if_fetch_unit_pkg;

   localparam int          INST_ADDR_BUS = 32;
   localparam int          INST_BUS      = 32;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic        CHIP_ENABLE   = 1'b1;
   localparam logic        CHIP_DISABLE  = 1'b0;
   localparam logic        RST_ENABLE    = 1'b1;
   localparam logic        STOP          = 1'b1;
   localparam logic        NO_STOP       = 1'b0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: owns PC, drives the combinational ROM, registers IF/ID one cycle after pc is presented.
// Stalls hold the PC (branches arriving meanwhile are parked); flush always wins.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = INST_ADDR_BUS,
   parameter int                INST_W   = INST_BUS,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_if,
   input  logic              stall_id,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic [INST_W-1:0] rom_inst,
   output logic              rom_ce,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [ADDR_W-1:0] id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic              id_valid,
   output logic [31:0]       fetch_count
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pend_target;
   logic              pend_valid;
   logic              eff_stall_if;
   logic              accept;

   // stall_id without stall_if is not a legal ctrl output; treat it as a full stall.
   always_comb begin
      eff_stall_if = stall_if | stall_id;
      accept       = rom_ce & ~flush & ~stall_id & ~eff_stall_if;
      rom_addr     = (rom_ce == CHIP_ENABLE) ? pc : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         state       <= IDLE;
         rom_ce      <= CHIP_DISABLE;
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else begin
         case (state)
            IDLE: begin
               state  <= RUN;
               rom_ce <= CHIP_ENABLE;
            end
            RUN: begin
               rom_ce <= CHIP_ENABLE;
               if (flush) begin
                  pc         <= new_pc;
                  pend_valid <= 1'b0;
               end else if (eff_stall_if) begin
                  if (branch_flag) begin
                     pend_valid  <= 1'b1;
                     pend_target <= branch_target;
                  end
               end else if (pend_valid) begin
                  pc         <= pend_target;
                  pend_valid <= 1'b0;
               end else if (branch_flag) begin
                  pc <= branch_target;
               end else begin
                  pc <= pc + ADDR_W'(4);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLE) begin
         id_pc       <= '0;
         id_inst     <= '0;
         id_valid    <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         if (flush || (!stall_id && (eff_stall_if || rom_ce == CHIP_DISABLE))) begin
            id_pc    <= '0;
            id_inst  <= '0;
            id_valid <= 1'b0;
         end else if (accept) begin
            id_pc    <= pc;
            id_inst  <= rom_inst;
            id_valid <= 1'b1;
         end
         if (accept)
            fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: behavioural model feeds a scoreboard queue, a negedge monitor compares.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_if, stall_id, flush, branch_flag;
   logic [31:0] new_pc, branch_target;
   logic [31:0] rom_inst;
   logic        rom_ce;
   logic [31:0] rom_addr, id_pc, id_inst, fetch_count;
   logic        id_valid;

   if_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
      .new_pc(new_pc), .branch_flag(branch_flag), .branch_target(branch_target),
      .rom_inst(rom_inst), .rom_ce(rom_ce), .rom_addr(rom_addr), .id_pc(id_pc),
      .id_inst(id_inst), .id_valid(id_valid), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // ROM word i holds 0x1000_0000 + i
   assign rom_inst = 32'h1000_0000 + (rom_addr >> 2);

   typedef struct {
      logic        run;
      logic [31:0] pc;
      logic        pend_v;
      logic [31:0] pend_t;
      logic        id_v;
      logic [31:0] id_pc, id_inst, cnt;
   } model_t;

   typedef struct {
      logic        ce;
      logic [31:0] addr;
      logic        v;
      logic [31:0] pc, inst, cnt;
   } exp_t;

   int     n_tests = 0;
   int     n_fail  = 0;
   model_t m;
   exp_t   sb[$];
   exp_t   mon_e;
   logic [31:0] saved_pc, saved_inst, saved_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m.run = 1'b0; m.pc = 32'h0; m.pend_v = 1'b0; m.pend_t = 32'h0;
      m.id_v = 1'b0; m.id_pc = 32'h0; m.id_inst = 32'h0; m.cnt = 32'h0;
   endtask

   function automatic exp_t snap(input model_t s);
      exp_t e;
      e.ce = s.run; e.addr = s.run ? s.pc : 32'h0;
      e.v = s.id_v; e.pc = s.id_pc; e.inst = s.id_inst; e.cnt = s.cnt;
      return e;
   endfunction

   // One clock edge of the reference: what the fetch front end should hold afterwards.
   task automatic model_step();
      model_t o;
      o = m;
      if (!o.run) m.run = 1'b1;
      else if (flush) begin m.pc = new_pc; m.pend_v = 1'b0; end
      else if (stall_if || stall_id) begin
         if (branch_flag) begin m.pend_v = 1'b1; m.pend_t = branch_target; end
      end
      else if (o.pend_v) begin m.pc = o.pend_t; m.pend_v = 1'b0; end
      else if (branch_flag) m.pc = branch_target;
      else m.pc = o.pc + 32'd4;

      if (flush || (!stall_id && (stall_if || !o.run))) begin
         m.id_v = 1'b0; m.id_pc = 32'h0; m.id_inst = 32'h0;
      end else if (!stall_id) begin
         m.id_v = 1'b1; m.id_pc = o.pc; m.id_inst = 32'h1000_0000 + (o.pc >> 2);
         m.cnt = o.cnt + 32'd1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      sb.push_back(snap(m));
      #2;
   endtask

   task automatic idle_inputs();
      stall_if = 0; stall_id = 0; flush = 0; branch_flag = 0;
      new_pc = 32'h0; branch_target = 32'h0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("sb_rom_ce",   {31'h0, rom_ce},   {31'h0, mon_e.ce});
            chk("sb_rom_addr", rom_addr,          mon_e.addr);
            chk("sb_id_valid", {31'h0, id_valid}, {31'h0, mon_e.v});
            chk("sb_id_pc",    id_pc,             mon_e.pc);
            chk("sb_id_inst",  id_inst,           mon_e.inst);
            chk("sb_count",    fetch_count,       mon_e.cnt);
         end
      end
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset_rom_ce", {31'h0, rom_ce}, 32'h0);
      chk("reset_count", fetch_count, 32'h0);
      rst = 1'b0;
      #1;
      chk("c0_rom_ce", {31'h0, rom_ce}, 32'h0);
      chk("c0_id_valid", {31'h0, id_valid}, 32'h0);
      #1;
      tick();
      chk("c1_rom_addr", rom_addr, 32'h0);
      chk("c1_rom_ce", {31'h0, rom_ce}, 32'h1);
      tick();
      chk("c2_id_inst", id_inst, 32'h1000_0000);
      chk("c2_id_pc", id_pc, 32'h0);
      tick();
      tick();
      chk("pre_br_id_pc", id_pc, 32'h8);
      branch_flag = 1; branch_target = 32'h40;
      tick();
      branch_flag = 0;
      chk("delay_slot_pc", id_pc, 32'hC);
      tick();
      chk("target_pc", id_pc, 32'h40);
      chk("count_5", fetch_count, 32'd5);

      branch_flag = 1; branch_target = 32'h10;
      tick();
      saved_cnt = fetch_count;
      stall_if = 1; branch_flag = 1; branch_target = 32'h80;
      tick();
      branch_flag = 0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) tick();
         chk("stall_pc_hold", rom_addr, 32'h10);
         chk("stall_bubble", {31'h0, id_valid}, 32'h0);
         chk("stall_count", fetch_count, saved_cnt);
      end
      stall_if = 0;
      tick();
      chk("pend_fetch", rom_addr, 32'h80);

      saved_pc = id_pc; saved_inst = id_inst;
      stall_if = 1; stall_id = 1;
      repeat (2) begin
         tick();
         chk("hold_id_pc", id_pc, saved_pc);
         chk("hold_id_inst", id_inst, saved_inst);
         chk("hold_id_valid", {31'h0, id_valid}, 32'h1);
      end
      stall_id = 0; branch_flag = 1; branch_target = 32'h60;
      tick();
      branch_flag = 0; flush = 1; new_pc = 32'h20;
      tick();
      chk("flush_id_valid", {31'h0, id_valid}, 32'h0);
      chk("flush_pc", rom_addr, 32'h20);
      idle_inputs();
      tick();
      chk("flush_resume", id_pc, 32'h20);
      chk("flush_no_pend", rom_addr, 32'h24);

      branch_flag = 1; branch_target = 32'hFFFF_FFFC;
      tick();
      branch_flag = 0;
      tick();
      chk("wrap_addr", rom_addr, 32'h0);

      for (int i = 0; i < 2000; i++) begin
         stall_if      = ($urandom_range(0, 3) == 0);
         stall_id      = ($urandom_range(0, 9) == 0);
         flush         = ($urandom_range(0, 19) == 0);
         new_pc        = $urandom;
         branch_flag   = ($urandom_range(0, 6) == 0);
         branch_target = $urandom;
         tick();
      end

      idle_inputs();
      flush = 1; new_pc = 32'h3C;
      tick();
      flush = 0; stall_if = 1; branch_flag = 1; branch_target = 32'h200;
      tick();
      #1;
      rst = 1'b1;
      #1;
      chk("async_rom_ce", {31'h0, rom_ce}, 32'h0);
      chk("async_rom_addr", rom_addr, 32'h0);
      chk("async_id_valid", {31'h0, id_valid}, 32'h0);
      chk("async_id_pc", id_pc, 32'h0);
      chk("async_count", fetch_count, 32'h0);
      model_reset();
      sb.delete();
      sb.push_back(snap(m));
      idle_inputs();
      @(posedge clk);
      #2;
      rst = 1'b0;
      tick();
      chk("post_rst_addr", rom_addr, 32'h0);
      tick();
      chk("post_rst_no_pend", rom_addr, 32'h4);
      tick();

      repeat (2) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
